// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TAKE  = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int unsigned MATCH_W = 32;

    // x0 is hardwired zero, so it never produces a hazard or a forward.
    function automatic logic reg_match(input logic [MATCH_W-1:0] x,
                                       input logic [MATCH_W-1:0] rd,
                                       input logic               en);
        return en && (rd != '0) && (rd == x);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline status in / stall-flush-forward controls out for the hazard sequencer.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              rf_en_e;
    logic              rf_en_m;
    logic              rf_en_w;
    logic              rd_en_e;
    logic              br_taken_e;
    logic              jump_e;
    logic              irq_req;

    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              irq_ack;
    logic              busy;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output rf_en_e, rf_en_m, rf_en_w, rd_en_e, br_taken_e, jump_e, irq_req,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_sel, fwd_b_sel, irq_ack, busy
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  rf_en_e, rf_en_m, rf_en_w, rd_en_e, br_taken_e, jump_e, irq_req,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_sel, fwd_b_sel, irq_ack, busy
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// E-stage operand forward select: M result beats W result, else regfile.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              en_m,
    input  logic              en_w,
    output logic [1:0]        sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (reg_match(MATCH_W'(rs), MATCH_W'(rd_m), en_m)) begin
            sel_c = FWD_M;
        end else if (reg_match(MATCH_W'(rs), MATCH_W'(rd_w), en_w)) begin
            sel_c = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard sequencer: stalls, flushes, forwarding and interrupt drain.
// HAZARD_FWD_EN selects operand forwarding; otherwise any RAW dependency stalls D.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

    hz_state_e        state;
    hz_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic       redirect_c;
    logic       hz_stall_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    assign redirect_c = hz.br_taken_e | hz.jump_e;

`ifdef HAZARD_FWD_EN
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs    (hz.rs1_e),
        .rd_m  (hz.rd_m),
        .rd_w  (hz.rd_w),
        .en_m  (hz.rf_en_m),
        .en_w  (hz.rf_en_w),
        .sel_c (fwd_a_c)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs    (hz.rs2_e),
        .rd_m  (hz.rd_m),
        .rd_w  (hz.rd_w),
        .en_m  (hz.rf_en_m),
        .en_w  (hz.rf_en_w),
        .sel_c (fwd_b_c)
    );

    // Only a load in E cannot be forwarded in time; everything else resolves via M/W.
    assign hz_stall_c = hz.rd_en_e &&
                        (reg_match(MATCH_W'(hz.rs1_d), MATCH_W'(hz.rd_e), hz.rf_en_e) ||
                         reg_match(MATCH_W'(hz.rs2_d), MATCH_W'(hz.rd_e), hz.rf_en_e));
`else
    logic raw_e_c;
    logic raw_m_c;
    logic raw_w_c;

    assign fwd_a_c = FWD_RF;
    assign fwd_b_c = FWD_RF;

    // Without bypass paths D waits until every producer has retired out of W.
    assign raw_e_c = reg_match(MATCH_W'(hz.rs1_d), MATCH_W'(hz.rd_e), hz.rf_en_e) ||
                     reg_match(MATCH_W'(hz.rs2_d), MATCH_W'(hz.rd_e), hz.rf_en_e);
    assign raw_m_c = reg_match(MATCH_W'(hz.rs1_d), MATCH_W'(hz.rd_m), hz.rf_en_m) ||
                     reg_match(MATCH_W'(hz.rs2_d), MATCH_W'(hz.rd_m), hz.rf_en_m);
    assign raw_w_c = reg_match(MATCH_W'(hz.rs1_d), MATCH_W'(hz.rd_w), hz.rf_en_w) ||
                     reg_match(MATCH_W'(hz.rs2_d), MATCH_W'(hz.rd_w), hz.rf_en_w);
    assign hz_stall_c = raw_e_c | raw_m_c | raw_w_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A redirect while draining restarts the bubble count so the new target settles first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (hz.irq_req && !redirect_c && !hz_stall_c) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (!hz.irq_req) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (redirect_c) begin
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES);
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = TAKE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            TAKE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        hz.stall_f   = 1'b0;
        hz.stall_d   = 1'b0;
        hz.flush_d   = 1'b0;
        hz.flush_e   = 1'b0;
        hz.fwd_a_sel = FWD_RF;
        hz.fwd_b_sel = FWD_RF;
        hz.irq_ack   = 1'b0;
        hz.busy      = 1'b0;
        if (rst) begin
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
        end else begin
            hz.fwd_a_sel = fwd_a_c;
            hz.fwd_b_sel = fwd_b_c;
            unique case (state)
                RUN: begin
                    hz.stall_f = hz_stall_c && !redirect_c;
                    hz.stall_d = hz_stall_c && !redirect_c;
                    hz.flush_d = redirect_c;
                    hz.flush_e = redirect_c || hz_stall_c;
                end
                DRAIN: begin
                    hz.stall_f = 1'b1;
                    hz.flush_d = 1'b1;
                    hz.flush_e = redirect_c;
                    hz.busy    = 1'b1;
                end
                TAKE: begin
                    hz.irq_ack = 1'b1;
                    hz.flush_d = 1'b1;
                    hz.flush_e = 1'b1;
                    hz.busy    = 1'b1;
                end
                default: begin
                    hz.busy = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int         DC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if #(.REG_AW(AW)) hz ();

    hazard_ctrl #(.REG_AW(AW), .DRAIN_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ack_cyc = -1;
    int irq_cyc = 0;
    // 0: running, >0: bubbles still to insert, -1: handing off to CSR
    int drain_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m(input int x, input int rd, input bit en);
        return en && (rd != 0) && (rd == x);
    endfunction

    task automatic clear_inputs();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
        hz.rd_e  = '0; hz.rd_m  = '0; hz.rd_w  = '0;
        hz.rf_en_e = 1'b0; hz.rf_en_m = 1'b0; hz.rf_en_w = 1'b0;
        hz.rd_en_e = 1'b0; hz.br_taken_e = 1'b0; hz.jump_e = 1'b0;
        hz.irq_req = 1'b0;
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic tick();
        int  d1, d2, e1, e2, re, rm, rw;
        bit  ene, enm, enw, redir, ld_use, raw_any, hzs, irq;
        int  fa, fb;
        bit  sf, sd, fd, fe, ack, busy;
        logic [9:0] exp_v, obs_v;
        #2;
        d1 = int'(hz.rs1_d); d2 = int'(hz.rs2_d);
        e1 = int'(hz.rs1_e); e2 = int'(hz.rs2_e);
        re = int'(hz.rd_e);  rm = int'(hz.rd_m);  rw = int'(hz.rd_w);
        ene = hz.rf_en_e; enm = hz.rf_en_m; enw = hz.rf_en_w;
        redir = hz.br_taken_e || hz.jump_e;
        irq   = hz.irq_req;
        ld_use  = hz.rd_en_e && (m(d1, re, ene) || m(d2, re, ene));
        raw_any = m(d1, re, ene) || m(d2, re, ene) || m(d1, rm, enm) ||
                  m(d2, rm, enm) || m(d1, rw, enw) || m(d2, rw, enw);
`ifdef HAZARD_FWD_EN
        hzs = ld_use;
        fa  = m(e1, rm, enm) ? 1 : (m(e1, rw, enw) ? 2 : 0);
        fb  = m(e2, rm, enm) ? 1 : (m(e2, rw, enw) ? 2 : 0);
`else
        hzs = raw_any;
        fa  = 0;
        fb  = 0;
`endif
        sf = 0; sd = 0; fd = 0; fe = 0; ack = 0; busy = 0;
        if (rst) begin
            fd = 1; fe = 1; fa = 0; fb = 0;
        end else if (drain_left == 0) begin
            sf = hzs && !redir;
            sd = hzs && !redir;
            fd = redir;
            fe = redir || hzs;
        end else if (drain_left > 0) begin
            sf = 1; fd = 1; fe = redir; busy = 1;
        end else begin
            ack = 1; fd = 1; fe = 1; busy = 1;
        end
        exp_v = {sf, sd, fd, fe, 2'(fa), 2'(fb), ack, busy};
        obs_v = {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e,
                 hz.fwd_a_sel, hz.fwd_b_sel, hz.irq_ack, hz.busy};
        check("outs", 32'(obs_v), 32'(exp_v));
        if (hz.irq_ack === 1'b1) ack_cyc = cyc;

        if (rst) drain_left = 0;
        else if (drain_left == 0) begin
            if (irq && !redir && !hzs) drain_left = DC;
        end else if (drain_left > 0) begin
            if (!irq)                 drain_left = 0;
            else if (redir)           drain_left = DC;
            else if (drain_left == 1) drain_left = -1;
            else                      drain_left = drain_left - 1;
        end else drain_left = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget && ack_cyc < 0; i++) tick();
    endtask

    initial begin
        clear_inputs();
        hz.br_taken_e = 1'b1;
        hz.irq_req    = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();

        // forwarding
        hz.rd_m = 5'd5; hz.rf_en_m = 1'b1; hz.rs1_e = 5'd5;
        tick();
        hz.rd_w = 5'd5; hz.rf_en_w = 1'b1;
        tick();
        clear_inputs();
        hz.rd_m = 5'd0; hz.rf_en_m = 1'b1; hz.rs1_e = 5'd0;
        tick();

        // load-use then M->E resolve
        clear_inputs();
        hz.rd_e = 5'd6; hz.rf_en_e = 1'b1; hz.rd_en_e = 1'b1; hz.rs2_d = 5'd6;
        tick();
        clear_inputs();
        hz.rd_m = 5'd6; hz.rf_en_m = 1'b1; hz.rs2_e = 5'd6;
        tick();

        // branch beats load-use
        clear_inputs();
        hz.rd_e = 5'd6; hz.rf_en_e = 1'b1; hz.rd_en_e = 1'b1; hz.rs2_d = 5'd6;
        hz.br_taken_e = 1'b1;
        tick();

        // producer walking E->M->W->gone
        clear_inputs();
        hz.rs1_d = 5'd7; hz.rd_e = 5'd7; hz.rf_en_e = 1'b1;
        tick();
        hz.rd_e = '0; hz.rf_en_e = 1'b0; hz.rd_m = 5'd7; hz.rf_en_m = 1'b1;
        tick();
        hz.rd_m = '0; hz.rf_en_m = 1'b0; hz.rd_w = 5'd7; hz.rf_en_w = 1'b1;
        tick();
        hz.rd_w = '0; hz.rf_en_w = 1'b0;
        tick();

        // interrupt entry, plain
        clear_inputs();
        tick();
        ack_cyc = -1; irq_cyc = cyc; hz.irq_req = 1'b1;
        wait_ack(20);
        hz.irq_req = 1'b0;
        check("irq_lat", 32'(ack_cyc - irq_cyc), 32'(DC + 1));
        tick();
        tick();

        // redirect on the second drain cycle
        ack_cyc = -1; irq_cyc = cyc; hz.irq_req = 1'b1;
        tick();
        tick();
        hz.jump_e = 1'b1;
        tick();
        hz.jump_e = 1'b0;
        wait_ack(20);
        hz.irq_req = 1'b0;
        check("irq_redir_lat", 32'(ack_cyc - irq_cyc), 32'(DC + 3));
        tick();

        // reset on first drain cycle
        ack_cyc = -1; hz.irq_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; hz.irq_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rst_no_ack", 32'(ack_cyc < 0 ? 0 : 1), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            hz.rs1_d = AW'($urandom_range(0, 3)); hz.rs2_d = AW'($urandom_range(0, 3));
            hz.rs1_e = AW'($urandom_range(0, 3)); hz.rs2_e = AW'($urandom_range(0, 3));
            hz.rd_e  = AW'($urandom_range(0, 3)); hz.rd_m  = AW'($urandom_range(0, 3));
            hz.rd_w  = AW'($urandom_range(0, 3));
            hz.rf_en_e = ($urandom_range(0, 2) == 0);
            hz.rf_en_m = ($urandom_range(0, 2) == 0);
            hz.rf_en_w = ($urandom_range(0, 2) == 0);
            hz.rd_en_e = ($urandom_range(0, 2) == 0);
            hz.br_taken_e = ($urandom_range(0, 11) == 0);
            hz.jump_e     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) hz.irq_req = ~hz.irq_req;
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
